// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver: frame FSM states,
// prefix byte values and the layout of one decoded FIFO entry.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Entry layout: {ext, brk, code[7:0]}
  localparam int ENTRY_W  = 10;
  localparam int CODE_LSB = 0;
  localparam int CODE_MSB = 7;
  localparam int BRK_BIT  = 8;
  localparam int EXT_BIT  = 9;

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// Decoded key-event stream. valid/ready: an entry transfers in any cycle where
// valid and ready are both high; the master holds code/brk/ext stable while valid && !ready.
interface ps2_scancode_rx_if;
  logic       valid;
  logic       ready;
  logic [7:0] code;
  logic       brk;
  logic       ext;

  modport master (output valid, output code, output brk, output ext, input ready);
  modport slave  (input valid, input code, input brk, input ext, output ready);
endinterface

// File: rtl/ps2_sync_fifo.sv
// First-word fall-through synchronous FIFO. A push while full is dropped and flagged
// unless a pop happens in the same cycle; head data reads as zero when empty.
module ps2_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     iClk,
  input  logic                     iReset_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     ready_i,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         data_o,
  output logic                     overflow_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             empty, full, pop, wr;

  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == LW'(DEPTH));
    pop        = ~empty & ready_i;
    wr         = push_i & (~full | pop);
    overflow_o = push_i & full & ~pop;
    wr_ptr_d   = wr  ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    case ({wr, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge iClk) begin
    if (wr) mem_q[wr_ptr_q] <= data_i;
  end

  assign valid_o = ~empty;
  assign data_o  = empty ? '0 : mem_q[rd_ptr_q];
  assign level_o = count_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronise and deglitch the pins, capture 11-bit frames,
// fold E0/F0 prefixes into flags and queue decoded key events in a small FIFO.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                        iClk,
  input  logic                        iReset_n,
  input  logic                        iPs2_Clk,
  input  logic                        iPs2_Data,
  input  logic                        iReady,
  output logic                        oValid,
  output logic [7:0]                  oCode,
  output logic                        oBreak,
  output logic                        oExtended,
  output logic                        oFrameErr,
  output logic                        oOverflow,
  output logic [$clog2(FIFO_DEPTH):0] oLevel
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic               clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic               dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic               filt_clk_q, filt_clk_d;
  logic [7:0]         filt_cnt_q, filt_cnt_d;
  ps2_state_e         state_q, state_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               parity_q, parity_d;
  logic [TW-1:0]      to_cnt_q, to_cnt_d;
  logic               ext_q, ext_d, brk_q, brk_d;
  logic               push_q, push_d;
  logic [ENTRY_W-1:0] push_data_q, push_data_d;
  logic               frame_err_q, frame_err_d;
  logic               fall, byte_ok, frame_fault;

  logic [ENTRY_W-1:0] head;
  logic               fifo_valid;

  always_comb begin
    clk_s1_d = iPs2_Clk;
    clk_s2_d = clk_s1_q;
    dat_s1_d = iPs2_Data;
    dat_s2_d = dat_s1_q;

    filt_clk_d = filt_clk_q;
    filt_cnt_d = '0;
    if (clk_s2_q != filt_clk_q) begin
      if (filt_cnt_q == 8'(FILTER_LEN - 1)) filt_clk_d = clk_s2_q;
      else                                  filt_cnt_d = filt_cnt_q + 8'd1;
    end
    fall = filt_clk_q & ~filt_clk_d;

    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    to_cnt_d    = to_cnt_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    frame_err_d = 1'b0;
    byte_ok     = 1'b0;
    frame_fault = 1'b0;

    case (state_q)
      IDLE: if (fall && !dat_s2_q) begin
        state_d   = DATA;
        bit_idx_d = '0;
      end
      DATA: if (fall) begin
        shift_d = {dat_s2_q, shift_q[7:1]};
        if (bit_idx_q == 3'd7) state_d = PARITY;
        else                   bit_idx_d = bit_idx_q + 3'd1;
      end
      PARITY: if (fall) begin
        parity_d = dat_s2_q;
        state_d  = STOP;
      end
      STOP: if (fall) begin
        state_d = IDLE;
        if ((^{shift_q, parity_q}) && dat_s2_q) byte_ok = 1'b1;
        else                                    frame_fault = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Watchdog restarts on every fall event so a stalled frame cannot wedge the FSM.
    if (state_q == IDLE) begin
      to_cnt_d = '0;
    end else if (fall) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d     = IDLE;
      frame_fault = 1'b1;
    end else begin
      to_cnt_d = to_cnt_q + TW'(1);
    end

    if (frame_fault) begin
      frame_err_d = 1'b1;
      ext_d       = 1'b0;
      brk_d       = 1'b0;
    end

    if (byte_ok) begin
      if (shift_q == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (shift_q == PS2_BRK) begin
        brk_d = 1'b1;
      end else begin
        push_d      = 1'b1;
        push_data_d = {ext_q, brk_q, shift_q};
        ext_d       = 1'b0;
        brk_d       = 1'b0;
      end
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      filt_clk_q  <= 1'b1;
      filt_cnt_q  <= '0;
      state_q     <= IDLE;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      to_cnt_q    <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      clk_s1_q    <= clk_s1_d;
      clk_s2_q    <= clk_s2_d;
      dat_s1_q    <= dat_s1_d;
      dat_s2_q    <= dat_s2_d;
      filt_clk_q  <= filt_clk_d;
      filt_cnt_q  <= filt_cnt_d;
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      to_cnt_q    <= to_cnt_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  ps2_scancode_rx_if out_if ();

  ps2_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .iClk       (iClk),
    .iReset_n   (iReset_n),
    .push_i     (push_q),
    .data_i     (push_data_q),
    .ready_i    (out_if.ready),
    .valid_o    (fifo_valid),
    .data_o     (head),
    .overflow_o (oOverflow),
    .level_o    (oLevel)
  );

  assign out_if.ready = iReady;
  assign out_if.valid = fifo_valid;
  assign out_if.code  = head[CODE_MSB:CODE_LSB];
  assign out_if.brk   = head[BRK_BIT];
  assign out_if.ext   = head[EXT_BIT];

  assign oValid    = out_if.valid;
  assign oCode     = out_if.code;
  assign oBreak    = out_if.brk;
  assign oExtended = out_if.ext;
  assign oFrameErr = frame_err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: bit-banged PS/2 frames against hand-computed
// key events, error pulses and FIFO occupancy.
module tb_ps2_scancode_rx;
  import ps2_pkg::*;

  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 200;
  localparam int FIFO_DEPTH  = 8;

  logic       clk;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       ready;
  logic       valid;
  logic [7:0] code;
  logic       brk;
  logic       ext;
  logic       frame_err;
  logic       overflow;
  logic [3:0] level;

  int n_checks = 0;
  int n_pass   = 0;
  int err_cyc  = 0;
  int ovf_cyc  = 0;

  ps2_scancode_rx_if mon_if ();
  assign mon_if.valid = valid;
  assign mon_if.code  = code;
  assign mon_if.brk   = brk;
  assign mon_if.ext   = ext;
  assign mon_if.ready = ready;

  ps2_scancode_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .iClk      (clk),
    .iReset_n  (rst_n),
    .iPs2_Clk  (ps2_clk),
    .iPs2_Data (ps2_dat),
    .iReady    (ready),
    .oValid    (valid),
    .oCode     (code),
    .oBreak    (brk),
    .oExtended (ext),
    .oFrameErr (frame_err),
    .oOverflow (overflow),
    .oLevel    (level)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no_finish expected finish");
    $fatal(1, "watchdog expired");
  end

  always @(negedge clk) begin
    if (rst_n && frame_err) err_cyc <= err_cyc + 1;
    if (rst_n && overflow)  ovf_cyc <= ovf_cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    wait_cyc(10);
    ps2_clk = 1'b0;
    wait_cyc(20);
    ps2_clk = 1'b1;
    wait_cyc(10);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~(^b) ^ bad_par);
    ps2_bit(1'b1);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] c, input logic bk, input logic ex);
    check({tag, "_valid"}, 32'(mon_if.valid), 32'd1);
    check({tag, "_code"},  32'(mon_if.code),  32'(c));
    check({tag, "_brk"},   32'(mon_if.brk),   32'(bk));
    check({tag, "_ext"},   32'(mon_if.ext),   32'(ex));
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  int e0, o0;

  initial begin
    rst_n   = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    ready   = 1'b0;
    wait_cyc(4);
    check("rst_valid", 32'(valid), 0);
    check("rst_code",  32'(code), 0);
    check("rst_brk",   32'(brk), 0);
    check("rst_ext",   32'(ext), 0);
    check("rst_ferr",  32'(frame_err), 0);
    check("rst_ovf",   32'(overflow), 0);
    check("rst_level", 32'(level), 0);
    rst_n = 1'b1;
    wait_cyc(4);

    // glitch shorter than the filter is ignored
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(30);
    check("glitch_valid", 32'(valid), 0);
    check("glitch_ferr",  32'(err_cyc), 0);

    // first frame 0x1C with stop-edge latency: sync 2 + filter 8 + decode/push 1
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(8'h1C >> i);
    ps2_bit(1'b0);
    ps2_dat = 1'b1;
    wait_cyc(10);
    ps2_clk = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 10) check("lat_before", 32'(valid), 0);
      if (k == 11) check("lat_at",     32'(valid), 1);
    end
    wait_cyc(9);
    ps2_clk = 1'b1;
    wait_cyc(10);
    check("f1_level", 32'(level), 1);
    pop_expect("f1", 8'h1C, 1'b0, 1'b0);
    check("f1_empty", 32'(valid), 0);
    check("f1_level0", 32'(level), 0);

    // break code
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    check("brk_level", 32'(level), 1);
    pop_expect("brk", 8'h1C, 1'b1, 1'b0);
    check("brk_level0", 32'(level), 0);

    // extended break
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    check("xbrk_level", 32'(level), 1);
    pop_expect("xbrk", 8'h75, 1'b1, 1'b1);

    // prefix cleared after use
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    send_frame(8'h75, 1'b0);
    check("pfx_level", 32'(level), 2);
    pop_expect("pfx_a", 8'h75, 1'b0, 1'b1);
    pop_expect("pfx_b", 8'h75, 1'b0, 1'b0);

    // parity error drops frame and pending E0
    e0 = err_cyc;
    send_frame(8'hE0, 1'b0);
    send_frame(8'h1C, 1'b1);
    check("perr_pulse", 32'(err_cyc - e0), 1);
    check("perr_level", 32'(level), 0);
    send_frame(8'h29, 1'b0);
    pop_expect("perr_next", 8'h29, 1'b0, 1'b0);

    // timeout mid-frame
    e0 = err_cyc;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    wait_cyc(250);
    check("tmo_pulse", 32'(err_cyc - e0), 1);
    check("tmo_level", 32'(level), 0);
    send_frame(8'h29, 1'b0);
    check("tmo_noerr", 32'(err_cyc - e0), 1);
    pop_expect("tmo_next", 8'h29, 1'b0, 1'b0);

    // overflow
    o0 = ovf_cyc;
    e0 = err_cyc;
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0);
    check("ovf_level", 32'(level), 8);
    check("ovf_pulse", 32'(ovf_cyc - o0), 1);
    check("ovf_noerr", 32'(err_cyc - e0), 0);
    for (int i = 1; i <= 8; i++) pop_expect($sformatf("ovf_pop%0d", i), 8'(i), 1'b0, 1'b0);
    check("ovf_empty", 32'(valid), 0);
    check("ovf_level0", 32'(level), 0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
